// File: rtl/rle_loader.sv
// rle_loader: decodes an escape-coded run-length byte stream from the download port
// into sequential memory writes starting at BASE.
module rle_loader #(
  parameter int AW = 16,
  parameter logic [AW-1:0] BASE = 16'h2000,
  parameter logic [7:0] ESC = 8'hED,
  parameter int TIMEOUT = 3000000
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          ioctl_download,
  input  logic [7:0]    ioctl_index,
  input  logic          ioctl_wr,
  input  logic [7:0]    ioctl_dout,
  output logic          ioctl_wait,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_data,
  output logic          mem_wr,
  input  logic          mem_ready,
  output logic          target_reset,
  output logic          busy,
  output logic          done,
  output logic [1:0]    error
);
  localparam int WDW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, LIT, CNT, VAL, RUN, END} state_t;
  state_t r_state, w_state;
  logic r_dl;
  logic [AW-1:0] r_addr, w_addr;
  logic [7:0] r_data, w_data, r_cnt, w_cnt;
  logic r_wr, w_wr, r_wait, w_wait, r_busy, w_busy, r_done, w_done, r_tr, w_tr;
  logic [1:0] r_err, w_err;
  logic [WDW-1:0] r_wd, w_wd;
  logic w_take, w_acc, w_step, w_rise, w_fall;

  assign ioctl_wait = r_wait | r_wr;
  assign w_take = ioctl_wr & ~ioctl_wait;
  assign w_acc = r_wr & mem_ready;
  // once the address has overflowed, run bytes are counted off without writing
  assign w_step = w_acc | r_err[0];
  assign w_rise = ioctl_download & ~r_dl & (|ioctl_index);
  assign w_fall = ~ioctl_download & r_dl & r_busy;

  assign mem_addr = r_addr;
  assign mem_data = r_data;
  assign mem_wr = r_wr;
  assign target_reset = r_tr;
  assign busy = r_busy;
  assign done = r_done;
  assign error = r_err;

  always_comb begin
    w_state = r_state;
    w_addr = r_addr;
    w_data = r_data;
    w_wr = r_wr;
    w_wait = r_wait;
    w_cnt = r_cnt;
    w_busy = r_busy;
    w_done = r_done;
    w_err = r_err;
    w_tr = 1'b0;
    w_wd = ioctl_wait ? r_wd + 1'b1 : '0;
    if (w_acc) begin
      w_addr = r_addr + 1'b1;
      w_wr = 1'b0;
      w_err[0] = r_err[0] | (&r_addr);
    end
    case (r_state)
      LIT: if (w_take) begin
        if (ioctl_dout == ESC) w_state = CNT;
        else begin
          w_data = ioctl_dout;
          w_wr = ~r_err[0];
        end
      end
      CNT: if (w_take) begin
        w_cnt = ioctl_dout;
        w_state = (ioctl_dout == 8'd0) ? END : VAL;
      end
      VAL: if (w_take) begin
        w_data = ioctl_dout;
        w_wait = 1'b1;
        w_wr = ~r_err[0];
        w_state = RUN;
      end
      RUN: if (w_step) begin
        w_cnt = r_cnt - 8'd1;
        if (r_cnt == 8'd1) begin
          w_wait = 1'b0;
          w_state = LIT;
        end else w_wr = ~w_err[0];
      end
      default: ;
    endcase
    if (ioctl_wait && r_wd == WDW'(TIMEOUT - 1)) begin
      w_err[1] = 1'b1;
      w_wait = 1'b0;
      w_wr = 1'b0;
      w_wd = '0;
      w_state = END;
    end
    if (w_fall) begin
      w_state = IDLE;
      w_busy = 1'b0;
      w_done = 1'b1;
      w_wr = 1'b0;
      w_wait = 1'b0;
    end
    if (w_rise) begin
      w_state = LIT;
      w_addr = BASE;
      w_tr = 1'b1;
      w_busy = 1'b1;
      w_done = 1'b0;
      w_err = 2'b00;
      w_wr = 1'b0;
      w_wait = 1'b0;
      w_wd = '0;
    end
  end

  always_ff @(posedge clk_sys) begin
    r_dl <= ioctl_download;
    if (reset) begin
      r_state <= IDLE;
      r_addr <= BASE;
      r_data <= 8'd0;
      r_wr <= 1'b0;
      r_wait <= 1'b0;
      r_cnt <= 8'd0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_err <= 2'b00;
      r_tr <= 1'b0;
      r_wd <= '0;
    end else begin
      r_state <= w_state;
      r_addr <= w_addr;
      r_data <= w_data;
      r_wr <= w_wr;
      r_wait <= w_wait;
      r_cnt <= w_cnt;
      r_busy <= w_busy;
      r_done <= w_done;
      r_err <= w_err;
      r_tr <= w_tr;
      r_wd <= w_wd;
    end
  end
endmodule

// File: doc/rle_loader.md
RLE_LOADER -- requirements
Module: rle_loader

Interface
REQ-001 Parameters (name, default, meaning):
- AW, 16, memory address width.
- BASE, 16'h2000, first load address.
- ESC, 8'hED, run-escape byte.
- TIMEOUT, 3000000, watchdog limit in clk_sys cycles.
REQ-002 Ports (name  direction  width  meaning):
- clk_sys  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high.
- ioctl_download  in  1  download window active.
- ioctl_index  in  8  file index; nonzero selects this loader.
- ioctl_wr  in  1  input byte strobe.
- ioctl_dout  in  8  input byte.
- ioctl_wait  out  1  backpressure to sender.
- mem_addr  out  AW  write address.
- mem_data  out  8  write data.
- mem_wr  out  1  write request, level, held until accepted.
- mem_ready  in  1  downstream accepts when mem_wr & mem_ready.
- target_reset  out  1  one-cycle pulse at load start.
- busy  out  1  load in progress.
- done  out  1  sticky, last load finished.
- error  out  2  [0] address overflow, [1] watchdog timeout; sticky per load.

Function
REQ-003 States: IDLE, LIT, CNT, VAL, RUN, END.
REQ-004 Start: rising edge of ioctl_download with ioctl_index!=0 (any state) -> mem_addr=BASE, state LIT, target_reset=1 for exactly 1 cycle, busy=1, done=0, error=0, mem_wr=0, ioctl_wait=0.
REQ-005 LIT: accepted byte != ESC -> mem_data=byte, mem_wr=1; byte == ESC -> CNT, no write.
REQ-006 CNT: byte==0 -> END (end of stream); else run count=byte, -> VAL.
REQ-007 VAL: mem_data=byte, ioctl_wait=1 same edge, -> RUN.
REQ-008 RUN: issues count writes of mem_data back-to-back (one per accepted cycle); after last acceptance ioctl_wait=0 next cycle, -> LIT.
REQ-009 Acceptance: write completes on the cycle mem_wr & mem_ready; mem_addr increments by 1 on that edge; mem_wr drops unless another run write is due.
REQ-010 ioctl_wait=1 whenever a write is pending (mem_wr=1) or state RUN; a literal with mem_ready=1 costs 1 cycle, ioctl_wait may stay 0.
REQ-011 ioctl_wr while ioctl_wait=1 or mem_wr=1: byte ignored, no state change.
REQ-012 Overflow: write accepted at mem_addr=2^AW-1 -> error[0]=1, mem_addr wraps to 0 but all later writes this load suppressed (mem_wr stays 0, bytes still consumed, runs still counted).
REQ-013 END: all further bytes ignored; ioctl_wait=0.
REQ-014 Watchdog: ioctl_wait continuously 1 for TIMEOUT cycles -> error[1]=1, ioctl_wait=0, mem_wr=0, pending run dropped, -> END.
REQ-015 Falling edge of ioctl_download -> IDLE, busy=0, done=1, mem_wr=0, ioctl_wait=0; unfinished run discarded.
REQ-016 ioctl_index==0 downloads: no state change, no outputs affected.
REQ-017 Run count width 8 bits; count 1..255 valid; ESC literal encoded as ESC,1,ESC.

Reset
REQ-018 reset=1: state IDLE, mem_addr=BASE, mem_data=0, mem_wr=0, ioctl_wait=0, target_reset=0, busy=0, done=0, error=0, watchdog cleared; overrides all events same cycle, aborts any load.

Verification
REQ-019 Literals 41,42, mem_ready=1 -> writes 41@2000, 42@2001; target_reset one pulse; done=1 after download falls.
REQ-020 Bytes ED,03,55 then 66 -> 55@2000..2002, ioctl_wait high 3 cycles, then 66@2003.
REQ-021 ED,00,77 -> no writes, END, 77 ignored, done=1, error=0.
REQ-022 ED,04,AA with mem_ready toggling 1/0 -> 4 writes at 2000..2003, addr advances only on accepted cycles.
REQ-023 AW=4, BASE=E, 3 literals -> writes at E,F, error[0]=1, third suppressed.
REQ-024 TIMEOUT=10, ED,05,11, mem_ready=0 -> after 10 cycles error[1]=1, ioctl_wait=0, mem_wr=0; reset mid-run -> all outputs reset values next cycle.
